// File: rtl/itlb_refill_walker.sv
// iTLB miss walker: single-level linear page table read, then a one-cycle fill or page-fault pulse.
// Miss->mem_req 1 cycle, mem_ack->tlb_write/page_fault 1 cycle; optional WALKER_TIMEOUT_EN bounds the wait in REQ.
module itlb_refill_walker #(
  parameter int VA_W        = 32,
  parameter int PA_W        = 20,
  parameter int OFFSET_W    = 12,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tlb_miss,
  input  logic [VA_W-1:0]          miss_vaddr,
  input  logic [PA_W-1:0]          ptbr,
  output logic                     mem_req,
  output logic [PA_W-1:0]          mem_addr,
  input  logic                     mem_ack,
  input  logic [31:0]              mem_rdata,
  output logic                     tlb_write,
  output logic [PA_W-OFFSET_W-1:0] physical_page_num_mem,
  output logic                     page_fault,
  output logic [VA_W-1:0]          fault_vaddr,
  output logic                     busy
);

  localparam int VPN_W = VA_W - OFFSET_W;
  localparam int PPN_W = PA_W - OFFSET_W;

  typedef enum logic [2:0] {IDLE, REQ, FILL, FAULT, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [PA_W-1:0]   pte_addr_q, pte_addr_d;
  logic [VA_W-1:0]   vaddr_q, vaddr_d;
  logic [PPN_W-1:0]  ppn_q, ppn_d;
  logic [VA_W-1:0]   fault_vaddr_q, fault_vaddr_d;
  logic [VPN_W+1:0]  pte_off;
  logic              unused_rdata;

`ifdef WALKER_TIMEOUT_EN
  logic [7:0]        cnt_q, cnt_d;
`endif

  // PTE index scaled by 4 bytes; the sum deliberately wraps at PA_W bits
  assign pte_off      = {miss_vaddr[VA_W-1:OFFSET_W], 2'b00};
  assign unused_rdata = ^mem_rdata[30:PPN_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pte_addr_q    <= '0;
      vaddr_q       <= '0;
      ppn_q         <= '0;
      fault_vaddr_q <= '0;
`ifdef WALKER_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      pte_addr_q    <= pte_addr_d;
      vaddr_q       <= vaddr_d;
      ppn_q         <= ppn_d;
      fault_vaddr_q <= fault_vaddr_d;
`ifdef WALKER_TIMEOUT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    pte_addr_d    = pte_addr_q;
    vaddr_d       = vaddr_q;
    ppn_d         = ppn_q;
    fault_vaddr_d = fault_vaddr_q;
`ifdef WALKER_TIMEOUT_EN
    cnt_d         = cnt_q;
`endif
    mem_req       = 1'b0;
    tlb_write     = 1'b0;
    page_fault    = 1'b0;
    case (state_q)
      IDLE: begin
        if (tlb_miss) begin
          vaddr_d    = miss_vaddr;
          pte_addr_d = ptbr + pte_off[PA_W-1:0];
          state_d    = REQ;
`ifdef WALKER_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          if (mem_rdata[31]) begin
            ppn_d   = mem_rdata[PPN_W-1:0];
            state_d = FILL;
          end else begin
            fault_vaddr_d = vaddr_q;
            state_d       = FAULT;
          end
        end
`ifdef WALKER_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
          fault_vaddr_d = vaddr_q;
          state_d       = FAULT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      FILL: begin
        tlb_write = 1'b1;
        state_d   = DRAIN;
      end
      FAULT: begin
        page_fault = 1'b1;
        state_d    = DRAIN;
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr              = pte_addr_q;
  assign physical_page_num_mem = ppn_q;
  assign fault_vaddr           = fault_vaddr_q;
  assign busy                  = (state_q != IDLE);

endmodule

// File: tb/tb_itlb_refill_walker.sv
// Directed bench for itlb_refill_walker: vector table of single walks plus zero-wait, reset and timeout sequences.
module tb_itlb_refill_walker;

  logic        clk = 1'b0;
  logic        reset;
  logic        tlb_miss;
  logic [31:0] miss_vaddr;
  logic [19:0] ptbr;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        tlb_write;
  logic [7:0]  physical_page_num_mem;
  logic        page_fault;
  logic [31:0] fault_vaddr;
  logic        busy;

  always #5 clk = ~clk;

  itlb_refill_walker dut (
    .clk                   (clk),
    .reset                 (reset),
    .tlb_miss              (tlb_miss),
    .miss_vaddr            (miss_vaddr),
    .ptbr                  (ptbr),
    .mem_req               (mem_req),
    .mem_addr              (mem_addr),
    .mem_ack               (mem_ack),
    .mem_rdata             (mem_rdata),
    .tlb_write             (tlb_write),
    .physical_page_num_mem (physical_page_num_mem),
    .page_fault            (page_fault),
    .fault_vaddr           (fault_vaddr),
    .busy                  (busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [19:0] ptbr;
    logic [31:0] va;
    logic [31:0] rdata;
    int          dly;
    logic [19:0] exp_addr;
    logic        exp_wr;
    logic [7:0]  exp_ppn;
  } vec_t;

  vec_t        vt[5];
  logic [7:0]  m_ppn;
  logic [31:0] m_fva;
  logic [7:0]  req_pat;
  logic [7:0]  wr_pat;
  int          cyc;

  initial begin
    vt[0] = '{20'h01000, 32'h00003ABC, 32'h800000A5, 3, 20'h0100C, 1'b1, 8'hA5};
    vt[1] = '{20'h01000, 32'h12345000, 32'h000000FF, 1, 20'h49D14, 1'b0, 8'h00};
    vt[2] = '{20'hFFFF0, 32'h00008000, 32'h8000003C, 0, 20'h00010, 1'b1, 8'h3C};
    vt[3] = '{20'h00000, 32'hFFFFF123, 32'h7FFFFFFF, 2, 20'hFFFFC, 1'b0, 8'h00};
    vt[4] = '{20'h12340, 32'h00400000, 32'hFFFFFF11, 0, 20'h13340, 1'b1, 8'h11};
    m_ppn = 8'h00;
    m_fva = 32'h0;

    reset = 1'b1; tlb_miss = 1'b0; miss_vaddr = '0; ptbr = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_addr", {12'b0, mem_addr}, 32'd0);
    chk("rst_tlb_write", {31'b0, tlb_write}, 32'd0);
    chk("rst_page_fault", {31'b0, page_fault}, 32'd0);
    chk("rst_ppn", {24'b0, physical_page_num_mem}, 32'd0);
    chk("rst_fault_vaddr", fault_vaddr, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tlb_miss = 1'b1; ptbr = vt[i].ptbr; miss_vaddr = vt[i].va;
      @(negedge clk);
      chk($sformatf("v%0d_req", i), {31'b0, mem_req}, 32'd1);
      chk($sformatf("v%0d_addr", i), {12'b0, mem_addr}, {12'b0, vt[i].exp_addr});
      chk($sformatf("v%0d_busy", i), {31'b0, busy}, 32'd1);
      tlb_miss = 1'b0; ptbr = ~vt[i].ptbr; miss_vaddr = ~vt[i].va;
      for (int k = 0; k < vt[i].dly; k++) begin
        chk($sformatf("v%0d_wait%0d", i, k), {31'b0, mem_req}, 32'd1);
        @(negedge clk);
      end
      chk($sformatf("v%0d_addr_hold", i), {12'b0, mem_addr}, {12'b0, vt[i].exp_addr});
      mem_ack = 1'b1; mem_rdata = vt[i].rdata;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = '0;
      if (vt[i].exp_wr) m_ppn = vt[i].exp_ppn;
      else              m_fva = vt[i].va;
      chk($sformatf("v%0d_tlb_write", i), {31'b0, tlb_write}, {31'b0, vt[i].exp_wr});
      chk($sformatf("v%0d_page_fault", i), {31'b0, page_fault}, {31'b0, ~vt[i].exp_wr});
      chk($sformatf("v%0d_ppn", i), {24'b0, physical_page_num_mem}, {24'b0, m_ppn});
      chk($sformatf("v%0d_fault_vaddr", i), fault_vaddr, m_fva);
      chk($sformatf("v%0d_req_drop", i), {31'b0, mem_req}, 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_drain_pulse", i), {30'b0, tlb_write, page_fault}, 32'd0);
      chk($sformatf("v%0d_drain_busy", i), {31'b0, busy}, 32'd1);
      @(negedge clk);
      chk($sformatf("v%0d_idle_busy", i), {31'b0, busy}, 32'd0);
    end

    // Zero-wait memory with the miss held: REQ, FILL, DRAIN, IDLE repeating
    req_pat = 8'b0001_0001;
    wr_pat  = 8'b0010_0010;
    tlb_miss = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h80000077; ptbr = 20'h0; miss_vaddr = 32'h00001000;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("zw%0d_req", c), {31'b0, mem_req}, {31'b0, req_pat[c]});
      chk($sformatf("zw%0d_write", c), {31'b0, tlb_write}, {31'b0, wr_pat[c]});
      if (req_pat[c]) chk($sformatf("zw%0d_addr", c), {12'b0, mem_addr}, 32'h4);
    end
    tlb_miss = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    m_ppn = 8'h77;
    chk("zw_ppn", {24'b0, physical_page_num_mem}, {24'b0, m_ppn});
    @(negedge clk);
    chk("zw_idle", {31'b0, busy}, 32'd0);

    // Reset while waiting in REQ, then a stray ack
    tlb_miss = 1'b1; ptbr = 20'h01000; miss_vaddr = 32'h00005000;
    @(negedge clk);
    chk("rr_req", {31'b0, mem_req}, 32'd1);
    tlb_miss = 1'b0; reset = 1'b1;
    @(negedge clk);
    m_ppn = 8'h00; m_fva = 32'h0;
    chk("rr_req_clr", {31'b0, mem_req}, 32'd0);
    chk("rr_busy_clr", {31'b0, busy}, 32'd0);
    chk("rr_addr_clr", {12'b0, mem_addr}, 32'd0);
    chk("rr_fva_clr", fault_vaddr, m_fva);
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h800000AA;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = '0;
    chk("rr_stray_write", {31'b0, tlb_write}, 32'd0);
    chk("rr_stray_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    chk("rr_stray_ppn", {24'b0, physical_page_num_mem}, {24'b0, m_ppn});
    chk("rr_stray_idle", {30'b0, tlb_write, busy}, 32'd0);

    // No ack: count REQ cycles under a bound
    tlb_miss = 1'b1; ptbr = 20'h0; miss_vaddr = 32'hDEAD0000;
    @(negedge clk);
    tlb_miss = 1'b0;
    cyc = 0;
    while (mem_req && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
`ifdef WALKER_TIMEOUT_EN
    chk("to_req_cycles", cyc, 32'd64);
    chk("to_page_fault", {31'b0, page_fault}, 32'd1);
    chk("to_fault_vaddr", fault_vaddr, 32'hDEAD0000);
    chk("to_no_write", {31'b0, tlb_write}, 32'd0);
    @(negedge clk);
    chk("to_drain", {31'b0, busy}, 32'd1);
    @(negedge clk);
    chk("to_idle", {31'b0, busy}, 32'd0);
`else
    chk("nto_still_waiting", cyc, 32'd200);
    chk("nto_req", {31'b0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h80000042;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = '0;
    chk("nto_write", {31'b0, tlb_write}, 32'd1);
    chk("nto_ppn", {24'b0, physical_page_num_mem}, 32'h42);
    @(negedge clk);
    @(negedge clk);
    chk("nto_idle", {31'b0, busy}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/itlb_refill_walker.md
Name: itlb_refill_walker

Overview:
Miss handler on the fetch side. It turns an iTLB miss into a page-table read from main memory and returns the translation to the iTLB as a one-cycle write of the physical page number. If the page-table entry is invalid, it raises an instruction page fault instead. It sits between the iTLB and the memory arbiter, using a single-level linear page table rooted at ptbr.

Parameters:
VA_W, 32, virtual address width
PA_W, 20, physical address width
OFFSET_W, 12, page offset width; VPN_W = VA_W-OFFSET_W (20), PPN_W = PA_W-OFFSET_W (8)
TIMEOUT_CYC, 64, memory-ack timeout in cycles (used only with WALKER_TIMEOUT_EN)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
tlb_miss  in  1  iTLB miss indication, level, sampled in IDLE
miss_vaddr  in  VA_W  faulting fetch virtual address
ptbr  in  PA_W  page table base (physical), sampled at walk start
mem_req  out  1  memory read request, held until mem_ack
mem_addr  out  PA_W  PTE address, stable while mem_req=1
mem_ack  in  1  one-cycle pulse, mem_rdata valid same cycle
mem_rdata  in  32  PTE word: bit31 valid, bits[PPN_W-1:0] PPN, other bits ignored
tlb_write  out  1  one-cycle pulse to iTLB
physical_page_num_mem  out  PPN_W  PPN to install, valid when tlb_write=1
page_fault  out  1  one-cycle pulse, PTE invalid (or timeout)
fault_vaddr  out  VA_W  vaddr of the last fault, held until the next fault
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (sync, high): state=IDLE; mem_req=0, mem_addr=0, tlb_write=0, physical_page_num_mem=0, page_fault=0, fault_vaddr=0, busy=0. Reset in any state aborts the walk. A mem_ack arriving later is ignored in IDLE.
- States: IDLE, REQ, FILL, FAULT, DRAIN.
- IDLE:
  - if tlb_miss=1, latch vpn=miss_vaddr[VA_W-1:OFFSET_W], latch vaddr, and latch pte_addr=(ptbr + {vpn,2'b00}) mod 2^PA_W (truncated, wrap-around allowed).
  - -> REQ.
- REQ:
  - mem_req=1, mem_addr=pte_addr.
  - On mem_ack: capture mem_rdata. If bit31=1 -> FILL, else -> FAULT.
  - mem_ack in the same cycle REQ is entered is accepted (zero-wait memory).
- FILL: tlb_write=1 for exactly one cycle, physical_page_num_mem=mem_rdata[PPN_W-1:0]; -> DRAIN.
- FAULT: page_fault=1 for exactly one cycle, fault_vaddr=latched vaddr; -> DRAIN.
- DRAIN:
  - One cycle; lets the iTLB update and tlb_miss deassert. -> IDLE.
  - tlb_miss still high in IDLE starts a new walk (a refetch after a fill hit is expected to drop the miss).
- Latency: miss seen in IDLE -> mem_req next cycle; mem_ack in cycle N -> tlb_write/page_fault in cycle N+1. Minimum miss-to-write: 2 cycles with zero-wait ack.
- tlb_write and page_fault are never high together. mem_req deasserts the cycle after mem_ack.
- miss_vaddr and ptbr changes during a walk have no effect (latched values are used).
- physical_page_num_mem holds its last value outside FILL.

Optional Feature:
WALKER_TIMEOUT_EN:
- Defined: an 8-bit counter clears on entry to REQ and increments each REQ cycle without mem_ack. When it reaches TIMEOUT_CYC-1 without an ack, mem_req drops, the walker goes to FAULT (page_fault pulse, fault_vaddr latched), then DRAIN.
- Undefined: REQ waits indefinitely; no counter is present.

Test Plan:
- Reset mid-REQ: assert reset while mem_req=1 -> next cycle mem_req=0, busy=0, no tlb_write; a later mem_ack is ignored.
- Valid fill: ptbr=20'h01000, miss_vaddr=32'h00003ABC, mem_ack 3 cycles later with rdata=32'h800000A5 -> mem_addr=20'h0100C, tlb_write pulse with physical_page_num_mem=8'hA5.
- Invalid PTE: rdata=32'h000000FF for miss_vaddr=32'h12345000 -> page_fault pulse, fault_vaddr=32'h12345000, tlb_write stays 0.
- Address wrap: ptbr=20'hFFFF0, vpn=20'h00008 -> mem_addr=20'h00010.
- Zero-wait memory: mem_ack held high -> mem_req one cycle, tlb_write 2 cycles after the miss; back-to-back misses separated by DRAIN.
- WALKER_TIMEOUT_EN, no ack: after TIMEOUT_CYC=64 REQ cycles -> mem_req=0, page_fault pulse, return to IDLE.
